// File: rtl/jtag_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_bus_pkg
// Description : Shared constants and types for the JTAG bus host: IR opcodes,
//               IR/DR widths, the 16-state TAP enum and the bus FSM enum.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_bus_pkg;

    localparam int unsigned c_ir_width     = 4;
    localparam int unsigned c_dr_max_width = 34;

    localparam logic [3:0] c_ir_capture = 4'b0101;
    localparam logic [3:0] c_op_idcode  = 4'h1;
    localparam logic [3:0] c_op_addr    = 4'h2;
    localparam logic [3:0] c_op_wdata   = 4'h3;
    localparam logic [3:0] c_op_rdata   = 4'h4;

    typedef enum logic [3:0] {
        TAP_RESET      = 4'd0,
        TAP_IDLE       = 4'd1,
        TAP_SELECT_DR  = 4'd2,
        TAP_CAPTURE_DR = 4'd3,
        TAP_SHIFT_DR   = 4'd4,
        TAP_EXIT1_DR   = 4'd5,
        TAP_PAUSE_DR   = 4'd6,
        TAP_EXIT2_DR   = 4'd7,
        TAP_UPDATE_DR  = 4'd8,
        TAP_SELECT_IR  = 4'd9,
        TAP_CAPTURE_IR = 4'd10,
        TAP_SHIFT_IR   = 4'd11,
        TAP_EXIT1_IR   = 4'd12,
        TAP_PAUSE_IR   = 4'd13,
        TAP_EXIT2_IR   = 4'd14,
        TAP_UPDATE_IR  = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2
    } bus_state_t;

    // Length of the data register selected by an instruction; unknown
    // opcodes fall back to the 1-bit bypass register.
    function automatic logic [5:0] dr_length(input logic [3:0] ir);
        case (ir)
            c_op_idcode, c_op_addr, c_op_wdata: return 6'd32;
            c_op_rdata:                         return 6'd34;
            default:                            return 6'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl
// Description : IEEE 1149.1 TAP controller state machine clocked in the
//               system domain; advances on synchronized TCK rising edges and
//               decodes single-cycle capture/shift/update strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
    import jtag_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tck_rise,
    input  logic       i_tms,
    output tap_state_t o_state,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr
);

    tap_state_t r_state;
    tap_state_t w_state_next;

    // State register, moved only on a TCK rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TAP_RESET;
        end else if (i_tck_rise) begin
            r_state <= w_state_next;
        end
    end

    // Standard TAP next-state function driven by TMS
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TAP_RESET:      w_state_next = i_tms ? TAP_RESET     : TAP_IDLE;
            TAP_IDLE:       w_state_next = i_tms ? TAP_SELECT_DR : TAP_IDLE;
            TAP_SELECT_DR:  w_state_next = i_tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: w_state_next = i_tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   w_state_next = i_tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   w_state_next = i_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   w_state_next = i_tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   w_state_next = i_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  w_state_next = i_tms ? TAP_SELECT_DR : TAP_IDLE;
            TAP_SELECT_IR:  w_state_next = i_tms ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: w_state_next = i_tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   w_state_next = i_tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   w_state_next = i_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   w_state_next = i_tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   w_state_next = i_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  w_state_next = i_tms ? TAP_SELECT_DR : TAP_IDLE;
            default:        w_state_next = TAP_RESET;
        endcase
    end

    // Capture/shift act on the rise that leaves the state; update fires on
    // the rise that enters Update-xR so the shift register is already final.
    assign o_state      = r_state;
    assign o_capture_ir = i_tck_rise && (r_state == TAP_CAPTURE_IR);
    assign o_shift_ir   = i_tck_rise && (r_state == TAP_SHIFT_IR);
    assign o_update_ir  = i_tck_rise && (w_state_next == TAP_UPDATE_IR);
    assign o_capture_dr = i_tck_rise && (r_state == TAP_CAPTURE_DR);
    assign o_shift_dr   = i_tck_rise && (r_state == TAP_SHIFT_DR);
    assign o_update_dr  = i_tck_rise && (w_state_next == TAP_UPDATE_DR);

endmodule
`default_nettype wire

// File: rtl/jtag_bus_host.sv
`default_nettype none
// ============================================================================
// Module      : jtag_bus_host
// Description : JTAG-controlled bus initiator. Oversamples TCK/TMS/TDI in the
//               clk_i domain, runs a TAP controller and turns Update-DR of the
//               WDATA/RDATA registers into single-word req/gnt/rvalid bus
//               transactions.
//               Build option JTAG_BUS_AUTOINC_EN: address register advances by
//               4 after every completed transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_bus_host
    import jtag_bus_pkg::*;
#(
    parameter logic [31:0] IdcodeValue = 32'h1000_0001,
    parameter int unsigned SyncStages  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        jtag_TCK,
    input  logic        jtag_TMS,
    input  logic        jtag_TDI,
    output logic        jtag_TDO,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i
);

    logic [SyncStages-1:0]     r_tck_sync, r_tms_sync, r_tdi_sync;
    logic                      r_tck_prev;
    logic                      w_tck, w_tms, w_tdi, w_tck_rise, w_tck_fall;

    tap_state_t                w_tap_state;
    logic                      w_capture_ir, w_shift_ir, w_update_ir;
    logic                      w_capture_dr, w_shift_dr, w_update_dr;

    logic [c_ir_width-1:0]     r_ir_shift, r_ir;
    logic [c_dr_max_width-1:0] r_dr_shift, w_dr_capture, w_dr_shifted;
    logic [5:0]                w_dr_len;
    logic                      r_tdo;

    logic [31:0]               r_addr, r_wdata, r_rdata, r_bus_addr;
    logic [31:0]               w_addr_base, w_addr_next;
    logic                      r_err, r_bus_we;
    bus_state_t                r_bus_state, w_bus_next;
    logic                      w_busy, w_launch_wr, w_launch_rd, w_accept, w_drop;
    logic                      w_addr_load, w_complete;

    // Pin synchronizers and TCK edge history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_prev <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[SyncStages-2:0], jtag_TCK};
            r_tms_sync <= {r_tms_sync[SyncStages-2:0], jtag_TMS};
            r_tdi_sync <= {r_tdi_sync[SyncStages-2:0], jtag_TDI};
            r_tck_prev <= w_tck;
        end
    end

    assign w_tck      = r_tck_sync[SyncStages-1];
    assign w_tms      = r_tms_sync[SyncStages-1];
    assign w_tdi      = r_tdi_sync[SyncStages-1];
    assign w_tck_rise = w_tck & ~r_tck_prev;
    assign w_tck_fall = ~w_tck & r_tck_prev;

    jtag_tap_ctrl u_tap (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_tck_rise   (w_tck_rise),
        .i_tms        (w_tms),
        .o_state      (w_tap_state),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir),
        .o_capture_dr (w_capture_dr),
        .o_shift_dr   (w_shift_dr),
        .o_update_dr  (w_update_dr)
    );

    // Instruction register; Test-Logic-Reset forces IDCODE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ir_shift <= '0;
            r_ir       <= c_op_idcode;
        end else if (w_tap_state == TAP_RESET) begin
            r_ir       <= c_op_idcode;
        end else begin
            if (w_capture_ir)
                r_ir_shift <= c_ir_capture;
            else if (w_shift_ir)
                r_ir_shift <= {w_tdi, r_ir_shift[c_ir_width-1:1]};
            if (w_update_ir)
                r_ir <= r_ir_shift;
        end
    end

    assign w_busy   = (r_bus_state != BUS_IDLE);
    assign w_dr_len = dr_length(r_ir);

    // DR capture value and right shift with TDI entering the selected MSB
    always_comb begin
        w_dr_capture = '0;
        case (r_ir)
            c_op_idcode: w_dr_capture[31:0] = IdcodeValue;
            c_op_addr:   w_dr_capture[31:0] = r_addr;
            c_op_wdata:  w_dr_capture[31:0] = r_wdata;
            c_op_rdata:  w_dr_capture       = {w_busy, r_err, r_rdata};
            default:     w_dr_capture       = '0;
        endcase
        w_dr_shifted = {1'b0, r_dr_shift[c_dr_max_width-1:1]};
        w_dr_shifted[w_dr_len - 6'd1] = w_tdi;
    end

    // Data shift register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_dr_shift <= '0;
        else if (w_capture_dr)
            r_dr_shift <= w_dr_capture;
        else if (w_shift_dr)
            r_dr_shift <= w_dr_shifted;
    end

    // TDO follows the shift register LSB on TCK fall, 0 outside Shift states
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tdo <= 1'b0;
        end else if (w_tck_fall) begin
            case (w_tap_state)
                TAP_SHIFT_IR: r_tdo <= r_ir_shift[0];
                TAP_SHIFT_DR: r_tdo <= r_dr_shift[0];
                default:      r_tdo <= 1'b0;
            endcase
        end
    end

    assign jtag_TDO = r_tdo;

    assign w_addr_load = w_update_dr && (r_ir == c_op_addr);
    assign w_launch_wr = w_update_dr && (r_ir == c_op_wdata);
    assign w_launch_rd = w_update_dr && (r_ir == c_op_rdata);
    assign w_accept    = (w_launch_wr || w_launch_rd) && !w_busy;
    assign w_drop      = (w_launch_wr || w_launch_rd) && w_busy;
    assign w_complete  = (r_bus_state == BUS_WAIT) && host_rvalid_i;

    // A new ADDR value takes effect at once; any increment builds on it
    assign w_addr_base = w_addr_load ? r_dr_shift[31:0] : r_addr;
`ifdef JTAG_BUS_AUTOINC_EN
    assign w_addr_next = w_complete ? (w_addr_base + 32'd4) : w_addr_base;
`else
    assign w_addr_next = w_addr_base;
`endif

    // Bus FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_bus_state <= BUS_IDLE;
        else
            r_bus_state <= w_bus_next;
    end

    // Bus FSM next state: one transaction outstanding at a time
    always_comb begin
        w_bus_next = r_bus_state;
        case (r_bus_state)
            BUS_IDLE: if (w_accept)      w_bus_next = BUS_REQ;
            BUS_REQ:  if (host_gnt_i)    w_bus_next = BUS_WAIT;
            BUS_WAIT: if (host_rvalid_i) w_bus_next = BUS_IDLE;
            default:                     w_bus_next = BUS_IDLE;
        endcase
    end

    // Address/data/status registers and the latched transaction attributes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_bus_addr <= '0;
            r_bus_we   <= 1'b0;
        end else begin
            r_addr <= w_addr_next;
            r_err  <= (r_err & ~w_addr_load) | w_drop | (w_complete & host_err_i);
            if (w_accept) begin
                r_bus_addr <= r_addr;
                r_bus_we   <= w_launch_wr;
                if (w_launch_wr)
                    r_wdata <= r_dr_shift[31:0];
            end
            if (w_complete && !r_bus_we)
                r_rdata <= host_rdata_i;
        end
    end

    assign host_req_o   = (r_bus_state == BUS_REQ);
    assign host_addr_o  = r_bus_addr;
    assign host_we_o    = r_bus_we;
    assign host_be_o    = {4{host_req_o}};
    assign host_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bus_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_bus_host
// Description : Directed self-checking bench for jtag_bus_host: JTAG scan
//               driver plus a small memory-like bus responder.
//               Expectations follow JTAG_BUS_AUTOINC_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_bus_host;

`ifdef JTAG_BUS_AUTOINC_EN
    localparam bit c_autoinc = 1'b1;
`else
    localparam bit c_autoinc = 1'b0;
`endif
    localparam int         c_half   = 6;
    localparam logic [3:0] OP_IDCODE = 4'h1;
    localparam logic [3:0] OP_ADDR   = 4'h2;
    localparam logic [3:0] OP_WDATA  = 4'h3;
    localparam logic [3:0] OP_RDATA  = 4'h4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jtag_TCK = 1'b0, jtag_TMS = 1'b0, jtag_TDI = 1'b0;
    logic        jtag_TDO;
    logic        host_req_o, host_we_o;
    logic [31:0] host_addr_o, host_wdata_o;
    logic [3:0]  host_be_o;
    logic        host_gnt_i, host_rvalid_i, host_err_i;
    logic [31:0] host_rdata_i;

    jtag_bus_host dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .jtag_TCK      (jtag_TCK),
        .jtag_TMS      (jtag_TMS),
        .jtag_TDI      (jtag_TDI),
        .jtag_TDO      (jtag_TDO),
        .host_req_o    (host_req_o),
        .host_gnt_i    (host_gnt_i),
        .host_addr_o   (host_addr_o),
        .host_we_o     (host_we_o),
        .host_be_o     (host_be_o),
        .host_wdata_o  (host_wdata_o),
        .host_rvalid_i (host_rvalid_i),
        .host_rdata_i  (host_rdata_i),
        .host_err_i    (host_err_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder controls (written by the main sequence only)
    int          gnt_delay = 2;
    logic        hold_gnt  = 1'b0;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr    = 32'h0;
    int          inject_req = 0;

    // Responder state (written by the responder only)
    logic [31:0] mem [logic [31:0]];
    int          inject_ack = 0;
    int          req_run = 0;
    int          last_req_len = 0;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
    logic        last_we = 1'b0;
    logic [3:0]  last_be = 4'h0;
    logic        resp_pend = 1'b0, resp_err = 1'b0;
    logic [31:0] resp_data = 32'h0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Bus responder: grant after gnt_delay req cycles, respond the next cycle;
    // anything at 0x005x_xxxx answers with an error.
    initial begin
        host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_rdata_i = 32'h0; host_err_i = 1'b0;
        forever begin
            @(negedge clk);
            host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_rdata_i = 32'h0; host_err_i = 1'b0;
            if (resp_pend) begin
                host_rvalid_i = 1'b1; host_rdata_i = resp_data; host_err_i = resp_err;
                resp_pend = 1'b0;
            end else if (inject_req != inject_ack) begin
                host_rvalid_i = 1'b1; host_rdata_i = 32'hCAFE_F00D;
                inject_ack = inject_req;
            end
            if (host_req_o) begin
                req_run++;
                if (!hold_gnt && req_run >= gnt_delay + 1) begin
                    host_gnt_i = 1'b1;
                    last_addr = host_addr_o; last_we = host_we_o;
                    last_be = host_be_o; last_wdata = host_wdata_o;
                    if (host_we_o) mem[host_addr_o] = host_wdata_o;
                    else resp_data = rd_ovr_en ? rd_ovr : mem_rd(host_addr_o);
                    resp_err  = (host_addr_o[31:20] == 12'h005);
                    resp_pend = 1'b1;
                end
            end else begin
                if (req_run != 0) last_req_len = req_run;
                req_run = 0;
            end
        end
    end

    // One TCK period; TDO is sampled just before the rising edge
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        jtag_TMS = tms; jtag_TDI = tdi;
        repeat (c_half) @(negedge clk);
        tdo = jtag_TDO;
        jtag_TCK = 1'b1;
        repeat (c_half) @(negedge clk);
        jtag_TCK = 1'b0;
    endtask

    task automatic tck_tms(input logic tms);
        logic d;
        tck_cycle(tms, 1'b0, d);
    endtask

    task automatic tap_reset();
        repeat (5) tck_tms(1'b1);
        tck_tms(1'b0);
    endtask

    task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
        logic b;
        cap = 4'h0;
        tck_tms(1'b1); tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, op[i], b);
            cap[i] = b;
        end
        tck_tms(1'b1); tck_tms(1'b0);
    endtask

    task automatic scan_dr(input logic [33:0] din, input int len, output logic [33:0] dout);
        logic b;
        dout = '0;
        tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], b);
            dout[i] = b;
        end
        tck_tms(1'b1); tck_tms(1'b0);
    endtask

    task automatic set_ir(input logic [3:0] op);
        logic [3:0] c;
        scan_ir(op, c);
    endtask

    task automatic put_dr(input logic [33:0] din, input int len);
        logic [33:0] d;
        scan_dr(din, len, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

    logic [3:0]  ir_cap;
    logic [33:0] dout;
    logic [31:0] exp_addr;

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req",   {33'h0, host_req_o}, 34'h0);
        check("rst_we",    {33'h0, host_we_o},  34'h0);
        check("rst_addr",  {2'b0, host_addr_o}, 34'h0);
        check("rst_wdata", {2'b0, host_wdata_o}, 34'h0);
        check("rst_tdo",   {33'h0, jtag_TDO},   34'h0);

        // IDCODE straight after Test-Logic-Reset, then explicit IR load
        tap_reset();
        scan_dr(34'h0, 32, dout);
        check("idcode", dout, 34'h0_1000_0001);
        scan_ir(OP_IDCODE, ir_cap);
        check("ir_capture", {30'h0, ir_cap}, 34'h5);

        // Bypass: captures 0, then passes TDI through with one bit delay
        set_ir(4'hF);
        scan_dr(34'h3, 2, dout);
        check("bypass", dout, 34'h2);

        // Write 0xDEADBEEF to 0x0010_0000, gnt after two req cycles
        gnt_delay = 2;
        set_ir(OP_ADDR);  put_dr(34'h0_0010_0000, 32);
        set_ir(OP_WDATA); put_dr(34'h0_DEAD_BEEF, 32);
        repeat (10) @(negedge clk);
        check("wr_req_len", 34'(last_req_len), 34'd3);
        check("wr_we",      {33'h0, last_we},  34'h1);
        check("wr_be",      {30'h0, last_be},  34'hF);
        check("wr_addr",    {2'b0, last_addr}, 34'h0_0010_0000);
        check("wr_mem",     {2'b0, mem_rd(32'h0010_0000)}, 34'h0_DEAD_BEEF);

        // Read back the RAM word; first capture shows the reset rdata
        set_ir(OP_ADDR);  put_dr(34'h0_0010_0000, 32);
        set_ir(OP_RDATA);
        scan_dr(34'h0, 34, dout);
        check("rd_init", dout, 34'h0);
        scan_dr(34'h0, 34, dout);
        check("rd_ram", dout, 34'h0_DEAD_BEEF);

        // Read with responder data 0x1234_5678; next read address shows autoinc
        rd_ovr_en = 1'b1; rd_ovr = 32'h1234_5678;
        set_ir(OP_ADDR);  put_dr(34'h0_0010_0000, 32);
        set_ir(OP_RDATA); put_dr(34'h0, 34);
        scan_dr(34'h0, 34, dout);
        check("rd_data", dout, 34'h0_1234_5678);
        check("rd_next_addr", {2'b0, last_addr},
              c_autoinc ? 34'h0_0010_0004 : 34'h0_0010_0000);
        rd_ovr_en = 1'b0;

        // Error response sets sticky err; ADDR update clears it
        set_ir(OP_ADDR);  put_dr(34'h0_0050_0000, 32);
        set_ir(OP_RDATA); put_dr(34'h0, 34);
        scan_dr(34'h0, 34, dout);
        check("err_set", {32'h0, dout[33:32]}, 34'h1);
        set_ir(OP_ADDR);  put_dr(34'h0_0010_0000, 32);
        set_ir(OP_RDATA);
        scan_dr(34'h0, 34, dout);
        check("err_clear", {32'h0, dout[33:32]}, 34'h0);
        exp_addr = c_autoinc ? 32'h0010_0004 : 32'h0010_0000;

        // Second launch while the first write is stalled is dropped
        hold_gnt = 1'b1;
        set_ir(OP_WDATA);
        put_dr(34'h0_AAAA_5555, 32);
        put_dr(34'h0_1111_2222, 32);
        set_ir(OP_RDATA);
        scan_dr(34'h0, 34, dout);
        check("busy_err", {32'h0, dout[33:32]}, 34'h3);
        check("req_held", {33'h0, host_req_o}, 34'h1);
        check("wdata_keep", {2'b0, host_wdata_o}, 34'h0_AAAA_5555);
        hold_gnt = 1'b0;
        repeat (10) @(negedge clk);
        check("first_wr_addr", {2'b0, last_addr}, {2'b0, exp_addr});
        check("first_wr_mem", {2'b0, mem_rd(exp_addr)}, 34'h0_AAAA_5555);
        check("req_done", {33'h0, host_req_o}, 34'h0);

        // Top-of-memory write with immediate gnt; then probe the address reg
        gnt_delay = 0;
        set_ir(OP_ADDR);  put_dr(34'h0_FFFF_FFFC, 32);
        set_ir(OP_WDATA); put_dr(34'h0_5A5A_5A5A, 32);
        repeat (10) @(negedge clk);
        check("req_1cyc", 34'(last_req_len), 34'd1);
        check("top_addr", {2'b0, last_addr}, 34'h0_FFFF_FFFC);
        set_ir(OP_RDATA); put_dr(34'h0, 34);
        repeat (10) @(negedge clk);
        check("wrap_addr", {2'b0, last_addr}, c_autoinc ? 34'h0 : 34'h0_FFFF_FFFC);

        // Reset during REQ drops req at once; a late rvalid is ignored
        hold_gnt = 1'b1;
        put_dr(34'h0, 34);
        repeat (4) @(negedge clk);
        check("req_pre_rst", {33'h0, host_req_o}, 34'h1);
        rst = 1'b1;
        #1;
        check("req_rst_drop", {33'h0, host_req_o}, 34'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        inject_req++;
        repeat (4) @(negedge clk);
        hold_gnt = 1'b0;
        check("late_rvalid_req", {33'h0, host_req_o}, 34'h0);
        tap_reset();
        set_ir(OP_RDATA);
        scan_dr(34'h0, 34, dout);
        check("late_rvalid_ignored", dout, 34'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
